// File: rtl/hypot_seq.sv
// Sequential floor(sqrt(x^2 + y^2)) built around one shared 9x9 multiplier.
// Squares both operands, sums them, then runs a 9-step trial-squaring root.
module hypot_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic        busy,
    output logic        done,
    output logic [8:0]  result,
    output logic [16:0] sum_sq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQX,
        S_SQY,
        S_ROOT,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, y_q;
    logic [16:0] acc_q;
    logic [8:0]  root_q;
    logic [3:0]  bit_q;
    logic [8:0]  trial;
    logic [8:0]  mul_a;
    logic [17:0] prod;

    assign trial = root_q | (9'd1 << bit_q);

    // Single multiplier; the operand is chosen by the current step
    always_comb begin
        mul_a = '0;
        unique case (state_q)
            S_SQX:   mul_a = {1'b0, x_q};
            S_SQY:   mul_a = {1'b0, y_q};
            S_ROOT:  mul_a = trial;
            default: mul_a = '0;
        endcase
    end

    assign prod = 18'(mul_a) * 18'(mul_a);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SQX;
            S_SQX:   state_d = S_SQY;
            S_SQY:   state_d = S_ROOT;
            S_ROOT:  if (bit_q == 4'd0) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            root_q <= '0;
            bit_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            sum_sq <= '0;
        end else if (ena) begin
            busy <= (state_d != S_IDLE);
            done <= (state_q == S_FIN);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q    <= x;
                        y_q    <= y;
                        acc_q  <= '0;
                        root_q <= '0;
                    end
                end
                S_SQX: begin
                    acc_q <= prod[16:0];
                end
                S_SQY: begin
                    acc_q <= acc_q + prod[16:0];
                    bit_q <= 4'd8;
                end
                S_ROOT: begin
                    // 18-bit compare keeps oversized trials from being taken
                    if (prod <= {1'b0, acc_q}) root_q <= trial;
                    if (bit_q != 4'd0) bit_q <= bit_q - 4'd1;
                end
                S_FIN: begin
                    result <= root_q;
                    sum_sq <= acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_seq.sv
// Self-checking bench for hypot_seq: directed table, corner sequences
// and random operands against an arithmetic reference.
module tb_hypot_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic        busy;
    logic        done;
    logic [8:0]  result;
    logic [16:0] sum_sq;

    int errors = 0;
    int checks = 0;

    hypot_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .result (result),
        .sum_sq (sum_sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int er;
        int es;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int isqrt(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // One operation; returns sampling in the done cycle.
    // stall_at/stall_len drop ena, coll_at injects a start while busy.
    task automatic run(input int a, input int b, input int er, input int es,
                       input int lat, input int stall_at, input int stall_len,
                       input int coll_at, input string nm);
        int   cyc;
        int   bad_busy;
        int   bad_hold;
        int   bad_frz;
        logic [8:0]  r0;
        logic [16:0] s0;
        logic        snap_b;
        r0 = result;
        s0 = sum_sq;
        snap_b = 1'b0;
        bad_busy = 0;
        bad_hold = 0;
        bad_frz = 0;
        x = 8'(a);
        y = 8'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
            if (stall_at >= 0 && cyc > stall_at && cyc <= stall_at + stall_len) begin
                if (busy !== snap_b || done !== 1'b0 ||
                    result !== r0 || sum_sq !== s0)
                    bad_frz++;
            end
            if (!done) begin
                if (busy !== 1'b1) bad_busy++;
                if (result !== r0 || sum_sq !== s0) bad_hold++;
            end
            if (cyc == stall_at) begin
                ena = 1'b0;
                snap_b = busy;
            end
            if (stall_at >= 0 && cyc == stall_at + stall_len) ena = 1'b1;
            if (cyc == coll_at) begin
                x = 8'd255;
                y = 8'd255;
                start = 1'b1;
            end
            if (coll_at >= 0 && cyc == coll_at + 1) start = 1'b0;
        end
        ena = 1'b1;
        start = 1'b0;
        chk({nm, " latency"}, cyc, lat);
        chk({nm, " result"}, int'(result), er);
        chk({nm, " sum_sq"}, int'(sum_sq), es);
        chk({nm, " busy_low"}, int'(busy), 0);
        chk({nm, " busy_gaps"}, bad_busy, 0);
        chk({nm, " out_hold"}, bad_hold, 0);
        if (stall_at >= 0) chk({nm, " frozen"}, bad_frz, 0);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{3, 4, 5, 25});
        tbl.push_back('{12, 5, 13, 169});
        tbl.push_back('{255, 255, 360, 130050});
        tbl.push_back('{0, 0, 0, 0});
        tbl.push_back('{255, 0, 255, 65025});
        tbl.push_back('{1, 1, 1, 2});
        tbl.push_back('{0, 255, 255, 65025});

        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst result", int'(result), 0);
        chk("rst sum_sq", int'(sum_sq), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].a, tbl[i].b, tbl[i].er, tbl[i].es, 12, -1, 0, -1,
                $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d pulse", i), int'(done), 0);
        end

        // collision: second start at E5 must be dropped
        run(3, 4, 5, 25, 12, -1, 0, 4, "collide");
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) begin
                chk("collide extra", int'({busy, done}), 0);
                break;
            end
        end

        // ena stall of 4 cycles during ROOT
        run(6, 8, 10, 100, 16, 4, 4, -1, "stall");

        // done pulse stretches while ena is low
        ena = 1'b0;
        tick();
        tick();
        chk("stretch done", int'(done), 1);
        ena = 1'b1;
        tick();
        chk("stretch end", int'(done), 0);

        // start with ena low is ignored
        ena = 1'b0;
        start = 1'b1;
        x = 8'd9;
        y = 8'd9;
        tick();
        start = 1'b0;
        ena = 1'b1;
        tick();
        chk("ena0 start", int'(busy), 0);

        // back-to-back: start asserted in the done cycle
        run(3, 4, 5, 25, 12, -1, 0, -1, "b2b_a");
        run(8, 15, 17, 289, 12, -1, 0, -1, "b2b_b");
        tick();

        // reset mid-ROOT
        x = 8'd200;
        y = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst done", int'(done), 0);
        chk("mid rst result", int'(result), 0);
        chk("mid rst sum_sq", int'(sum_sq), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post rst idle", int'({busy, done}), 0);
        run(200, 100, 223, 50000, 12, -1, 0, -1, "after_rst");
        tick();

        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            run(a, b, isqrt(a * a + b * b), a * a + b * b, 12, -1, 0, -1,
                $sformatf("rnd%0d(%0d,%0d)", i, a, b));
            if ($urandom_range(1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
